// File: rtl/csi2tx_dphy_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csi2tx_dphy_pkg: clock-lane state encodings, defaults, output decode   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package csi2tx_dphy_pkg;

  localparam int NUM_LANES_DEF = 8;
  localparam int CNT_W_DEF     = 16;

  localparam logic [2:0] ST_STOP      = 3'd0;
  localparam logic [2:0] ST_HS_REQ    = 3'd1;
  localparam logic [2:0] ST_HS_ON     = 3'd2;
  localparam logic [2:0] ST_HS_HOLD   = 3'd3;
  localparam logic [2:0] ST_HS_EXIT   = 3'd4;
  localparam logic [2:0] ST_ULPS      = 3'd5;
  localparam logic [2:0] ST_ULPS_EXIT = 3'd6;

  localparam logic [2:0] CLK_STATE_RST = ST_STOP;

  typedef struct packed {
    logic req_hs;
    logic hs_ready;
    logic ulps;
    logic ulps_exit;
  } clk_outs_t;

  // Moore decode; the top registers it from the next state.
  function automatic clk_outs_t state_outputs(input logic [2:0] st);
    clk_outs_t o;
    o = '0;
    case (st)
      ST_HS_REQ:    o.req_hs = 1'b1;
      ST_HS_ON,
      ST_HS_HOLD: begin
        o.req_hs   = 1'b1;
        o.hs_ready = 1'b1;
      end
      ST_ULPS:      o.ulps = 1'b1;
      ST_ULPS_EXIT: begin
        o.ulps      = 1'b1;
        o.ulps_exit = 1'b1;
      end
      default:      o = '0;
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csi2tx_dphy_clk_ctrl_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csi2tx_dphy_clk_ctrl_cnt: loadable down-counter saturating at zero     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module csi2tx_dphy_clk_ctrl_cnt
  import csi2tx_dphy_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/csi2tx_dphy_clk_lane_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | csi2tx_dphy_clk_lane_ctrl: D-PHY clock lane HS/ULPS sequencer          |
// | CSI2TX_CLK_CONT_MODE_EN selects continuous clock.  Rev 1.0             |
// +-----------------------------------------------------------------------+
module csi2tx_dphy_clk_lane_ctrl
  import csi2tx_dphy_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 txclkesc,
  input  logic                 txescclk_rst,
  input  logic [NUM_LANES-1:0] lane_hs_req,
  input  logic                 ulps_req,
  input  logic                 ulps_exit_req,
  input  logic [CNT_W-1:0]     cfg_idle_cnt,
  input  logic [CNT_W-1:0]     cfg_wakeup_cnt,
  input  logic                 frd_sot,
  input  logic                 mas_stopstate_clk,
  output logic                 txrequesths_clk,
  output logic                 txulpsclk,
  output logic                 txulpsexit_clk,
  output logic                 clk_hs_ready,
  output logic [2:0]           clk_state
);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  clk_outs_t        outs_q;
  logic             any_req;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign any_req = |lane_hs_req;

`ifdef CSI2TX_CLK_CONT_MODE_EN
  logic unused_idle_cnt;
  assign unused_idle_cnt = ^cfg_idle_cnt;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (mas_stopstate_clk) begin
`ifdef CSI2TX_CLK_CONT_MODE_EN
          // The clock restarts by itself unless ULPS is wanted with no lane busy.
          if (any_req || !ulps_req) state_d = ST_HS_REQ;
          else                      state_d = ST_ULPS;
`else
          if (any_req)       state_d = ST_HS_REQ;
          else if (ulps_req) state_d = ST_ULPS;
`endif
        end
      end
      ST_HS_REQ: begin
        if (frd_sot) state_d = ST_HS_ON;
      end
      ST_HS_ON: begin
`ifdef CSI2TX_CLK_CONT_MODE_EN
        if (ulps_req) begin
          state_d      = ST_HS_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = '0;
        end
`else
        if (!any_req) begin
          state_d      = ST_HS_HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = cfg_idle_cnt;
        end
`endif
      end
      ST_HS_HOLD: begin
`ifdef CSI2TX_CLK_CONT_MODE_EN
        if (cnt_zero) state_d = ST_HS_EXIT;
        else          cnt_dec = 1'b1;
`else
        if (any_req)       state_d = ST_HS_ON;
        else if (cnt_zero) state_d = ST_HS_EXIT;
        else               cnt_dec = 1'b1;
`endif
      end
      ST_HS_EXIT: begin
        if (mas_stopstate_clk) state_d = ST_STOP;
      end
      ST_ULPS: begin
        if (ulps_exit_req) begin
          state_d      = ST_ULPS_EXIT;
          cnt_load     = 1'b1;
          cnt_load_val = cfg_wakeup_cnt;
        end
      end
      ST_ULPS_EXIT: begin
        if (cnt_zero) state_d = ST_STOP;
        else          cnt_dec = 1'b1;
      end
      default: state_d = ST_STOP;
    endcase
  end

  csi2tx_dphy_clk_ctrl_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i      (txclkesc),
    .rst_i      (txescclk_rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge txclkesc) begin
    if (txescclk_rst) begin
      state_q <= CLK_STATE_RST;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= state_outputs(state_d);
    end
  end

  assign txrequesths_clk = outs_q.req_hs;
  assign clk_hs_ready    = outs_q.hs_ready;
  assign txulpsclk       = outs_q.ulps;
  assign txulpsexit_clk  = outs_q.ulps_exit;
  assign clk_state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_csi2tx_dphy_clk_lane_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_csi2tx_dphy_clk_lane_ctrl: vectors, corner sequences, random+model  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_csi2tx_dphy_clk_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lane_req;
  logic        ulps, ulpsx, sot, stp;
  logic [15:0] idle_cnt, wake_cnt;
  logic        o_req, o_ulps, o_ulpsx, o_rdy;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;

  // Model: phase numbers follow the published clk_state values; timers are
  // absolute edge numbers at which the phase must end.
  int cyc = 0;
  int m_ph = 0;
  int deadline = 0;

  always #5 clk = ~clk;

  csi2tx_dphy_clk_lane_ctrl dut (
    .txclkesc          (clk),
    .txescclk_rst      (rst),
    .lane_hs_req       (lane_req),
    .ulps_req          (ulps),
    .ulps_exit_req     (ulpsx),
    .cfg_idle_cnt      (idle_cnt),
    .cfg_wakeup_cnt    (wake_cnt),
    .frd_sot           (sot),
    .mas_stopstate_clk (stp),
    .txrequesths_clk   (o_req),
    .txulpsclk         (o_ulps),
    .txulpsexit_clk    (o_ulpsx),
    .clk_hs_ready      (o_rdy),
    .clk_state         (o_state)
  );

  function automatic logic [6:0] dut_so();
    return {o_state, o_req, o_rdy, o_ulps, o_ulpsx};
  endfunction

  function automatic logic [6:0] model_so();
    logic hs, rdy, up, ux;
    hs  = (m_ph >= 1 && m_ph <= 3);
    rdy = (m_ph == 2 || m_ph == 3);
    up  = (m_ph == 5 || m_ph == 6);
    ux  = (m_ph == 6);
    return {3'(m_ph), hs, rdy, up, ux};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_ph = 0;
    end else begin
      case (m_ph)
        0: if (stp) begin
`ifdef CSI2TX_CLK_CONT_MODE_EN
          if (lane_req != 0) m_ph = 1;
          else if (ulps)     m_ph = 5;
          else               m_ph = 1;
`else
          if (lane_req != 0) m_ph = 1;
          else if (ulps)     m_ph = 5;
`endif
        end
        1: if (sot) m_ph = 2;
        2: begin
`ifdef CSI2TX_CLK_CONT_MODE_EN
          if (ulps) begin m_ph = 3; deadline = cyc + 1; end
`else
          if (lane_req == 0) begin m_ph = 3; deadline = cyc + int'(idle_cnt) + 1; end
`endif
        end
        3: begin
`ifdef CSI2TX_CLK_CONT_MODE_EN
          if (cyc >= deadline) m_ph = 4;
`else
          if (lane_req != 0)        m_ph = 2;
          else if (cyc >= deadline) m_ph = 4;
`endif
        end
        4: if (stp) m_ph = 0;
        5: if (ulpsx) begin m_ph = 6; deadline = cyc + int'(wake_cnt) + 1; end
        6: if (cyc >= deadline) m_ph = 0;
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic chk_so(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d state/outs actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic u, input logic ux,
                      input logic s, input logic st);
    rst = r; lane_req = rq; ulps = u; ulpsx = ux; sot = s; stp = st;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk_so("model", dut_so(), model_so());
  endtask

  typedef struct {
    logic       r;
    logic [7:0] rq;
    logic       u, ux, s, st;
    logic [2:0] exp_st;
    logic [3:0] exp_o;   // {txrequesths_clk, clk_hs_ready, txulpsclk, txulpsexit_clk}
  } vec_t;

  vec_t tbl [14];
  int   n;
  int   hi;

  initial begin
    rst = 1'b1; lane_req = '0; ulps = 0; ulpsx = 0; sot = 0; stp = 0;
    idle_cnt = '0; wake_cnt = '0;
    #1;

`ifndef CSI2TX_CLK_CONT_MODE_EN
    // Table walk with idle/wakeup counts of zero.
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000};
    tbl[2]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'b1000};
    tbl[3]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'b1000};
    tbl[4]  = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 4'b1100};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'b1100};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 4'b0000};
    tbl[7]  = '{1'b0, 8'hff, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 4'b0000};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 4'b0010};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 4'b0010};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 4'b0011};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 4'b0000};
    tbl[13] = '{1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000};
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].rq, tbl[i].u, tbl[i].ux, tbl[i].s, tbl[i].st);
      chk_so($sformatf("vec%0d", i), dut_so(), {tbl[i].exp_st, tbl[i].exp_o});
    end

    // HS request latency and SoT handshake.
    step(1, 8'h00, 0, 0, 0, 0);
    step(0, 8'h01, 0, 0, 0, 1);
    chk_int("hs_req_after_1_edge", int'(o_req), 1);
    for (int i = 0; i < 4; i++) step(0, 8'h01, 0, 0, 0, 0);
    chk_int("ready_before_sot", int'(o_rdy), 0);
    step(0, 8'h01, 0, 0, 1, 0);
    chk_int("ready_after_sot", int'(o_rdy), 1);

    // Idle hold: short gap resumes HS_ON, long gap exits after idle+2 edges.
    idle_cnt = 16'd4;
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0, 0);
    step(0, 8'h08, 0, 0, 0, 0);
    chk_int("hold_resume_state", int'(o_state), 2);
    chk_int("hold_resume_req", int'(o_req), 1);
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      step(0, 8'h00, 0, 0, 0, 0);
      if (!o_req) begin n = i; break; end
    end
    chk_int("idle_exit_edges", n, 6);
    step(0, 8'h00, 0, 0, 0, 1);
    chk_int("exit_to_stop", int'(o_state), 0);

    // ULPS entry and 11-cycle wakeup pulse.
    step(0, 8'h00, 1, 0, 0, 1);
    chk_int("ulps_entry", int'(o_state), 5);
    step(0, 8'h00, 0, 0, 0, 1);
    chk_int("ulps_hold_on_req_drop", int'(o_ulps), 1);
    wake_cnt = 16'd10;
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 8'h00, 0, 1, 0, 1);
      if (o_ulpsx) hi++;
      else break;
    end
    chk_int("wakeup_high_cycles", hi, 11);
    chk_so("wakeup_done", dut_so(), 7'b000_0000);

    // Simultaneous HS and ULPS request: HS wins; ULPS only after STOP.
    idle_cnt = 16'd0;
    step(0, 8'h01, 1, 0, 0, 1);
    chk_int("hs_wins", int'(o_state), 1);
    step(0, 8'h00, 1, 0, 1, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0);
    chk_int("in_hs_exit", int'(o_state), 4);
    step(0, 8'h00, 1, 0, 0, 0);
    chk_int("ulps_ignored_in_exit", int'(o_state), 4);
    step(0, 8'h00, 1, 0, 0, 1);
    chk_int("stop_after_exit", int'(o_state), 0);
    step(0, 8'h00, 1, 0, 0, 1);
    chk_int("ulps_after_stop", int'(o_state), 5);

    // Reset mid-ULPS_EXIT and mid-HS_HOLD.
    wake_cnt = 16'd20;
    step(0, 8'h00, 0, 1, 0, 1);
    chk_int("in_ulps_exit", int'(o_state), 6);
    step(1, 8'h00, 0, 1, 0, 1);
    chk_so("rst_ulps_exit", dut_so(), 7'b000_0000);
    idle_cnt = 16'd20;
    step(0, 8'h02, 0, 0, 0, 1);
    step(0, 8'h02, 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    chk_int("in_hs_hold", int'(o_state), 3);
    step(1, 8'h00, 0, 0, 0, 0);
    chk_so("rst_hs_hold", dut_so(), 7'b000_0000);
`else
    // Continuous clock: restart without requests, stop only for ULPS.
    step(1, 8'h00, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1);
    chk_int("cont_hs_req", int'(o_state), 1);
    step(0, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 0, 0, 0, 0);
    chk_int("cont_stays_on", int'(o_state), 2);
    step(0, 8'h00, 1, 0, 0, 0);
    chk_int("cont_hold", int'(o_state), 3);
    step(0, 8'h00, 1, 0, 0, 0);
    chk_int("cont_exit", int'(o_state), 4);
    step(0, 8'h00, 1, 0, 0, 1);
    chk_int("cont_stop", int'(o_state), 0);
    step(0, 8'h00, 1, 0, 0, 1);
    chk_int("cont_ulps", int'(o_state), 5);
`endif

    // Randomized run against the model.
    step(1, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      idle_cnt = 16'($urandom_range(0, 7));
      wake_cnt = 16'($urandom_range(0, 7));
      step(($urandom % 64) == 0,
           (($urandom % 4) == 0) ? 8'($urandom) : 8'h00,
           ($urandom % 8) == 0,
           ($urandom % 4) == 0,
           ($urandom % 3) == 0,
           ($urandom % 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
